// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and datapath widths for the memory-access stage
package mem_stage_pkg;
  localparam int XLEN = 32;
  localparam int RLEN = 5;
  typedef enum logic {IDLE, ACCESS} state_e;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: writeback output registers; valid and error flags pulse for one cycle, the rest hold
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_i,
  input  logic            reg_write_i,
  input  logic [RLEN-1:0] write_reg_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            bus_err_i,
  input  logic            align_err_i,
  output logic            valid_o,
  output logic            reg_write_o,
  output logic [RLEN-1:0] write_reg_o,
  output logic [XLEN-1:0] data_o,
  output logic            bus_err_o,
  output logic            align_err_o
);
  logic            valid_q, reg_write_q, bus_err_q, align_err_q;
  logic [RLEN-1:0] write_reg_q;
  logic [XLEN-1:0] data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      data_q      <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      valid_q     <= ld_i;
      bus_err_q   <= ld_i && bus_err_i;
      align_err_q <= ld_i && align_err_i;
      if (ld_i) begin
        reg_write_q <= reg_write_i;
        write_reg_q <= write_reg_i;
        data_q      <= data_i;
      end
    end
  end
  assign valid_o     = valid_q;
  assign reg_write_o = reg_write_q;
  assign write_reg_o = write_reg_q;
  assign data_o      = data_q;
  assign bus_err_o   = bus_err_q;
  assign align_err_o = align_err_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS memory-access stage with req/ack data memory handshake and timeout.
// Define MEM_ALIGN_CHECK_EN to reject misaligned word accesses with align_err.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] rt_data,
  input  logic [RLEN-1:0] write_reg,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [RLEN-1:0] wb_write_reg,
  output logic [XLEN-1:0] wb_data,
  output logic            bus_err,
  output logic            align_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q, m2r_q, rw_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [RLEN-1:0] dst_q;
  logic            idle, access, mem_op, misalign, accept, tmo, ld;
  logic            wb_rw_d, bus_err_d;
  logic [RLEN-1:0] wb_reg_d;
  logic [XLEN-1:0] wb_data_d;
  assign idle   = state_q == IDLE;
  assign access = state_q == ACCESS;
  assign mem_op = mem_read || mem_write;
  assign accept = idle && in_valid;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op && (alu_res[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  // Compare one early so the request stays up for exactly TIMEOUT cycles.
  assign tmo = cnt_q == CW'(TIMEOUT - 1);
  assign ld  = (accept && (!mem_op || misalign)) || (access && (dmem_ack || tmo));
  always_comb begin
    wb_data_d = idle ? alu_res : ((dmem_ack && !we_q && m2r_q) ? dmem_rdata : addr_q);
    wb_rw_d   = idle ? (reg_write && !misalign) : (rw_q && dmem_ack);
    wb_reg_d  = idle ? write_reg : dst_q;
    bus_err_d = access && !dmem_ack && tmo;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dst_q   <= '0;
    end else if (idle) begin
      if (accept && mem_op && !misalign) begin
        state_q <= ACCESS;
        cnt_q   <= '0;
        we_q    <= mem_write;
        m2r_q   <= mem_to_reg;
        rw_q    <= reg_write;
        addr_q  <= alu_res;
        wdata_q <= rt_data;
        dst_q   <= write_reg;
      end
    end else if (dmem_ack || tmo) begin
      state_q <= IDLE;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
  assign in_ready   = idle;
  assign dmem_req   = access;
  assign dmem_we    = access && we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  mem_wb_reg u_wb (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_i        (ld),
    .reg_write_i (wb_rw_d),
    .write_reg_i (wb_reg_d),
    .data_i      (wb_data_d),
    .bus_err_i   (bus_err_d),
    .align_err_i (idle && misalign),
    .valid_o     (wb_valid),
    .reg_write_o (wb_reg_write),
    .write_reg_o (wb_write_reg),
    .data_o      (wb_data),
    .bus_err_o   (bus_err),
    .align_err_o (align_err)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven checks of mem_access_stage with TIMEOUT=4
module tb_mem_access_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, mem_read = 0, mem_write = 0, mem_to_reg = 0, reg_write = 0, dmem_ack = 0;
  logic [31:0] alu_res = '0, rt_data = '0, dmem_rdata = '0;
  logic [4:0] write_reg = '0;
  logic in_ready, dmem_req, dmem_we, wb_valid, wb_reg_write, bus_err, align_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0] wb_write_reg;
  int pass_cnt = 0, total_cnt = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_res(alu_res), .rt_data(rt_data), .write_reg(write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .bus_err(bus_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr, m2r, rw;
    logic [31:0] alu, rt;
    logic [4:0] dst;
    int dly;
    logic [31:0] rdata, exp_data;
    logic exp_rw;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1; mem_read = v.rd; mem_write = v.wr; mem_to_reg = v.m2r; reg_write = v.rw;
    alu_res = v.alu; rt_data = v.rt; write_reg = v.dst;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), in_ready, 1);
    drive(v);
    @(negedge clk);
    in_valid = 0;
    if (v.rd || v.wr) begin
      for (int k = 1; k <= v.dly; k++) begin
        chk($sformatf("v%0d req", idx), dmem_req, 1);
        chk($sformatf("v%0d busy", idx), in_ready, 0);
        chk($sformatf("v%0d we", idx), dmem_we, v.wr);
        chk($sformatf("v%0d addr", idx), dmem_addr, v.alu);
        if (v.wr) chk($sformatf("v%0d wdata", idx), dmem_wdata, v.rt);
        chk($sformatf("v%0d early_wb", idx), wb_valid, 0);
        if (k == v.dly) begin dmem_ack = 1; dmem_rdata = v.rdata; end
        @(negedge clk);
        dmem_ack = 0;
      end
    end
    chk($sformatf("v%0d wb_valid", idx), wb_valid, 1);
    chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
    chk($sformatf("v%0d wb_rw", idx), wb_reg_write, v.exp_rw);
    chk($sformatf("v%0d wb_reg", idx), wb_write_reg, v.dst);
    chk($sformatf("v%0d req_off", idx), dmem_req, 0);
    chk($sformatf("v%0d ready_after", idx), in_ready, 1);
    chk($sformatf("v%0d errs", idx), {bus_err, align_err}, 0);
    @(negedge clk);
    chk($sformatf("v%0d pulse_end", idx), wb_valid, 0);
    chk($sformatf("v%0d data_hold", idx), wb_data, v.exp_data);
  endtask

  initial begin
    int n;
    vecs[0] = '{0, 0, 0, 1, 32'h15, 32'h0, 5'd8, 0, 32'h0, 32'h15, 1'b1};
    vecs[1] = '{0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 5'd31, 0, 32'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1, 0, 1, 1, 32'h40, 32'h0, 5'd9, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{0, 1, 0, 0, 32'h80, 32'h1234, 5'd0, 1, 32'h0, 32'h80, 1'b0};
    vecs[4] = '{1, 0, 0, 1, 32'h44, 32'h0, 5'd3, 2, 32'h5555, 32'h44, 1'b1};
    vecs[5] = '{1, 1, 1, 1, 32'h88, 32'hABCD, 5'd7, 4, 32'h7777, 32'h88, 1'b1};
    #3;
    chk("rst ready", in_ready, 1);
    chk("rst outs", {dmem_req, dmem_we, wb_valid, wb_reg_write, bus_err, align_err}, 0);
    chk("rst data", wb_data | dmem_addr | dmem_wdata, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    // ack while idle is ignored
    @(negedge clk);
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    chk("idle_ack wb", wb_valid, 0);
    chk("idle_ack req", dmem_req, 0);
    // timeout: no ack, request for exactly TIMEOUT cycles
    @(negedge clk);
    drive('{1, 0, 1, 1, 32'h100, 32'h0, 5'd4, 0, 32'h0, 32'h0, 1'b0});
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (dmem_req && n < 10) begin n++; @(negedge clk); end
    chk("to req_cycles", n, 4);
    chk("to bus_err", bus_err, 1);
    chk("to wb_valid", wb_valid, 1);
    chk("to wb_rw", wb_reg_write, 0);
    chk("to ready", in_ready, 1);
    @(negedge clk);
    chk("to pulse_end", {bus_err, wb_valid}, 0);
    run_vec(vecs[0], 10);
    // reset during second ACCESS cycle
    @(negedge clk);
    drive('{1, 0, 1, 1, 32'h200, 32'h0, 5'd5, 0, 32'h0, 32'h0, 1'b0});
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("rst_mid req_before", dmem_req, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid req_drop", dmem_req, 0);
    chk("rst_mid ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    dmem_ack = 1;
    dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem_ack = 0;
    chk("rst_mid no_wb", wb_valid, 0);
    chk("rst_mid req", dmem_req, 0);
    @(negedge clk);
    chk("rst_mid no_wb2", wb_valid, 0);
    run_vec(vecs[2], 11);
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    drive('{1, 0, 1, 1, 32'h42, 32'h0, 5'd6, 0, 32'h0, 32'h0, 1'b0});
    @(negedge clk);
    in_valid = 0;
    chk("align req", dmem_req, 0);
    chk("align err", align_err, 1);
    chk("align wb_valid", wb_valid, 1);
    chk("align wb_rw", wb_reg_write, 0);
    chk("align ready", in_ready, 1);
    @(negedge clk);
    chk("align pulse_end", {align_err, wb_valid, dmem_req}, 0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the MIPS datapath, directly downstream of the execute stage. It consumes the ALU result (as address or as pass-through value), the store data and the destination register. It runs word loads and stores against a data memory with a request/acknowledge handshake and a timeout, then hands a single-cycle result pulse to writeback. While an access is outstanding it stalls upstream.

## Interface
Parameters:
- `TIMEOUT`, 16, maximum ACCESS cycles to wait for `dmem_ack` before abort; legal range ≥1.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: execute-stage result valid this cycle.
- `in_ready` output 1: stage can accept; upstream stall = `!in_ready`.
- `mem_read` input 1: load word.
- `mem_write` input 1: store word.
- `mem_to_reg` input 1: writeback selects load data, else `alu_res`.
- `reg_write` input 1: instruction writes the register file.
- `alu_res` input 32: address for memory ops, else result.
- `rt_data` input 32: store data.
- `write_reg` input 5: destination register.
- `dmem_req` output 1: memory request, held until ack or abort.
- `dmem_we` output 1: 1 = store.
- `dmem_addr` output 32: word address.
- `dmem_wdata` output 32: store data.
- `dmem_ack` input 1: one-cycle completion; `dmem_rdata` valid with it.
- `dmem_rdata` input 32: load data.
- `wb_valid` output 1: one-cycle result pulse to writeback.
- `wb_reg_write` output 1: register-file write enable.
- `wb_write_reg` output 5: destination register.
- `wb_data` output 32: writeback value.
- `bus_err` output 1: one-cycle pulse on timeout abort.
- `align_err` output 1: one-cycle pulse on misaligned access; tied 0 without the macro.

## Operation
- States: IDLE, ACCESS. `in_ready` = (state == IDLE).
- IDLE, `in_valid`, no memory op: register the result. Next cycle `wb_valid`=1, `wb_data`=`alu_res`, `wb_reg_write`=`reg_write`. Stay in IDLE.
- IDLE, `in_valid`, memory op: latch address, wdata, control and dest. Go to ACCESS and clear the timeout counter.
- If both `mem_read` and `mem_write` are set, the op is a store.
- ACCESS: `dmem_req`=1, with `dmem_we`/`dmem_addr`/`dmem_wdata` stable.
  - On `dmem_ack`: load → `wb_data` = `mem_to_reg` ? `dmem_rdata` : latched `alu_res`; store → `wb_data` = latched `alu_res`. `wb_reg_write` = latched `reg_write`. Pulse `wb_valid` next cycle and go to IDLE.
  - Counter increments each ACCESS cycle without ack. When the count reaches `TIMEOUT` with no ack: drop the request, go to IDLE, and the next cycle pulse `wb_valid`=1 with `wb_reg_write`=0 plus `bus_err`=1.
  - An ack in the same cycle as the timeout compare wins (normal completion).
- `dmem_ack` while in IDLE is ignored.
- Writeback never backpressures.
- All `wb_*` registers other than `wb_valid` hold their last value between pulses.

## Timing
- Reset: state IDLE, counter 0. All outputs 0 except `in_ready`=1.
- Reset asserted mid-access: `dmem_req` drops immediately, and no `wb_valid` is produced for the aborted op. A late ack after reset is ignored.
- Non-memory latency: accepted at cycle N → `wb_valid` at N+1.
- Memory latency: accepted at N → `dmem_req` from N+1. Ack at cycle M → `wb_valid` at M+1, and `in_ready` is 1 at M+1.
- Minimum memory latency is 2 cycles (ack at N+1).
- Timeout: the last request cycle is N+`TIMEOUT`; `bus_err` and `wb_valid` pulse at N+`TIMEOUT`+1.
- Counter width is $clog2(`TIMEOUT`+1). It never wraps.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: a memory op with `alu_res[1:0]` ≠ 0 issues no request and stays in IDLE. Next cycle: `wb_valid`=1, `wb_reg_write`=0, `align_err`=1.
- Not defined: `align_err` is constant 0. The full 32-bit address is driven unchanged to `dmem_addr`, with no check.

## Structure
- Package `mem_stage_pkg`: state enum (IDLE, ACCESS) and the word/register-index width constants (32, 5).
- One sub-module, `mem_wb_reg`: the writeback output register set (valid pulse, reg_write, dest, data, error flags), with load/clear controls driven by the FSM.

## Test plan
- Non-memory op: `alu_res`=0x0000_0015, `reg_write`=1, `write_reg`=8 → next cycle `wb_valid`=1, `wb_data`=0x15, `wb_write_reg`=8; `dmem_req` never rises.
- Load, ack after 3 cycles: addr 0x40, `dmem_rdata`=0xDEAD_BEEF, `mem_to_reg`=1 → `in_ready`=0 during ACCESS; `wb_data`=0xDEADBEEF the cycle after ack.
- Store with ack in the first request cycle: addr 0x80, `rt_data`=0x1234 → `dmem_we`=1, `dmem_wdata`=0x1234; `wb_valid` 2 cycles after accept with `wb_reg_write`=0.
- Timeout with `TIMEOUT`=4 and no ack → `dmem_req` high exactly 4 cycles, then `bus_err` and `wb_valid` pulse, `wb_reg_write`=0; next op accepted.
- `rst_n` pulled low during the second ACCESS cycle → `dmem_req`=0 immediately; no `wb_valid`; an ack after release is ignored.
- With `MEM_ALIGN_CHECK_EN`, load at 0x42 → no `dmem_req`; next cycle `align_err`=1, `wb_valid`=1, `wb_reg_write`=0.
